// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer: default sizes, op encodings, FSM states.
// Pure declarations; no latency or flow control of its own.
// Backpressure: not applicable.
package muldiv_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 40;

    // bit0 selects the divider, bit1 requests signed arithmetic
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FIX    = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational operand magnitude and result sign correction; built only with MULDIV_SIGNED_EN.
// Latency: zero (pure combinational).
// Backpressure: none; outputs follow inputs.
`ifdef MULDIV_SIGNED_EN
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot_neg;
    logic [WIDTH-1:0]   rem_neg;

    // Two's complement of the most negative value is itself, which is exactly its magnitude
    assign mag_a = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign prod     = {res_hi, res_lo};
    assign prod_neg = ~prod + 1'b1;
    assign quot_neg = ~res_lo + 1'b1;
    assign rem_neg  = ~res_hi + 1'b1;

    always_comb begin
        fix_hi = res_hi;
        fix_lo = res_lo;
        if (is_div) begin
            // Remainder follows the dividend, quotient follows the sign product
            fix_lo = (sign_a ^ sign_b) ? quot_neg : res_lo;
            fix_hi = sign_a ? rem_neg : res_hi;
        end else if (sign_a ^ sign_b) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule
`endif

// File: rtl/muldiv_ctrl.sv
// Runs one MULT/DIV at a time on the iterative engines and commits HI/LO; signed ops need MULDIV_SIGNED_EN.
// Latency: eng_start the cycle after accept; done/HI/LO one cycle after eng_done (two when sign fixing).
// Backpressure: req_ready only in IDLE; requests while busy are dropped, never queued.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             timeout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             eng_start,
    output logic             eng_sel,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_hi,
    input  logic [WIDTH-1:0] eng_lo
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic             accept;
    logic             div_zero_req;
    logic             to_hit;
    logic             fix_needed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    logic             commit;
    logic [WIDTH-1:0] commit_hi;
    logic [WIDTH-1:0] commit_lo;
    logic             set_done;
    logic             set_dz;
    logic             set_to;

    assign accept       = req_valid && (state == ST_IDLE);
    assign div_zero_req = accept && op_is_div(req_op) && (req_b == '0);
    // Abort on the edge that would bring the WAIT count up to TIMEOUT_CYCLES
    assign to_hit       = (count == CW'(TIMEOUT_CYCLES - 1));

`ifdef MULDIV_SIGNED_EN
    logic             req_signed;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign req_signed = op_is_signed(req_op);
    assign fix_needed = op_signed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
        end else begin
            if (accept) begin
                op_signed <= req_signed;
                sign_a    <= req_signed & req_a[WIDTH-1];
                sign_b    <= req_signed & req_b[WIDTH-1];
            end
            if (state == ST_WAIT && eng_done) begin
                res_hi <= eng_hi;
                res_lo <= eng_lo;
            end
        end
    end

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .a         (req_a),
        .b         (req_b),
        .signed_op (req_signed),
        .is_div    (eng_sel),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );
`else
    assign mag_a      = req_a;
    assign mag_b      = req_b;
    assign fix_needed = 1'b0;
    assign fix_hi     = eng_hi;
    assign fix_lo     = eng_lo;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && !div_zero_req) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    state_nxt = fix_needed ? ST_FIX : ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        commit    = 1'b0;
        commit_hi = eng_hi;
        commit_lo = eng_lo;
        set_done  = 1'b0;
        set_dz    = 1'b0;
        set_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (div_zero_req) begin
                    set_done = 1'b1;
                    set_dz   = 1'b1;
                end
            end
            ST_WAIT: begin
                // A completion arriving on the timeout edge still counts as success
                if (eng_done) begin
                    if (!fix_needed) begin
                        commit   = 1'b1;
                        set_done = 1'b1;
                    end
                end else if (to_hit) begin
                    set_done = 1'b1;
                    set_to   = 1'b1;
                end
            end
            ST_FIX: begin
                commit    = 1'b1;
                commit_hi = fix_hi;
                commit_lo = fix_lo;
                set_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign eng_start = (state == ST_LAUNCH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            eng_a    <= '0;
            eng_b    <= '0;
            eng_sel  <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done     <= set_done;
            div_zero <= set_dz;
            timeout  <= set_to;
            if (accept) begin
                eng_a   <= mag_a;
                eng_b   <= mag_b;
                eng_sel <= op_is_div(req_op);
            end
            if (state == ST_LAUNCH) begin
                count <= '0;
            end else if (state == ST_WAIT) begin
                count <= count + 1'b1;
            end
            if (commit) begin
                hi <= commit_hi;
                lo <= commit_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural engine and a result scoreboard.
// Expectations depend on MULDIV_SIGNED_EN being defined for both bench and design.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TO = 40;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        to;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        timeout;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        eng_start;
    logic        eng_sel;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        eng_done_m;
    logic        spur_done;
    logic [31:0] eng_hi;
    logic [31:0] eng_lo;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    int   start_cyc = 0;
    int   edone_cyc = 0;
    logic [31:0] st_a;
    logic [31:0] st_b;
    logic        st_sel;
    int   eng_delay = 32;
    bit   eng_mute = 0;
    logic [31:0] cur_hi = 0;
    logic [31:0] cur_lo = 0;
    exp_t sb_q[$];

    muldiv_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .timeout   (timeout),
        .hi        (hi),
        .lo        (lo),
        .eng_start (eng_start),
        .eng_sel   (eng_sel),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done_m | spur_done),
        .eng_hi    (eng_hi),
        .eng_lo    (eng_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (eng_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            st_a      = eng_a;
            st_b      = eng_b;
            st_sel    = eng_sel;
        end
        if (eng_done_m === 1'b1) edone_cyc = cyc;
        if (done === 1'b1) done_cnt++;
    end

    // Behavioural engine: unsigned magnitudes in, result eng_delay cycles after launch
    initial begin
        logic [31:0] ea, eb;
        logic        es, abort;
        logic [63:0] p;
        eng_done_m = 1'b0;
        eng_hi     = '0;
        eng_lo     = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && !eng_mute) begin
                ea = eng_a;
                eb = eng_b;
                es = eng_sel;
                abort = 1'b0;
                for (int i = 0; i < eng_delay; i++) begin
                    @(posedge clk);
                    if (!reset_n) abort = 1'b1;
                end
                if (!abort) begin
                    #1;
                    eng_done_m = 1'b1;
                    if (es) begin
                        eng_lo = (eb == 0) ? 32'hFFFF_FFFF : ea / eb;
                        eng_hi = (eb == 0) ? ea : ea % eb;
                    end else begin
                        p = {32'b0, ea} * {32'b0, eb};
                        eng_hi = p[63:32];
                        eng_lo = p[31:0];
                    end
                    @(posedge clk);
                    #1 eng_done_m = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] phi, input logic [31:0] plo, input bit mute);
        exp_t        e;
        logic        sgn;
        longint      sa, sb, q, r;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa = $signed(a);
        sb = $signed(b);
        e.hi = phi;
        e.lo = plo;
        e.dz = 1'b0;
        e.to = 1'b0;
        e.lat = sgn ? 2 : 1;
        if (op[0] && b == 0) begin
            e.dz = 1'b1;
            e.lat = 0;
        end else if (mute) begin
            e.to = 1'b1;
        end else if (!op[0]) begin
            p = sgn ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int delay, input bit mute, input bit poke);
        exp_t e, got_e;
        int   s0, n;
        bit   got;
        e = model(op, a, b, cur_hi, cur_lo, mute);
        sb_q.push_back(e);
        eng_delay = delay;
        eng_mute  = mute;
        s0 = start_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op = ~op;
        req_a = ~a;
        req_b = ~b;
        got = 1'b0;
        for (n = 0; n < 200; n++) begin
            req_valid = poke && (n >= 3) && (n < 6);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            got_e = sb_q.pop_front();
            chk({tag, "_hi"}, hi, got_e.hi);
            chk({tag, "_lo"}, lo, got_e.lo);
            chk({tag, "_div_zero"}, div_zero, got_e.dz);
            chk({tag, "_timeout"}, timeout, got_e.to);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_ready"}, req_ready, 1);
            if (got_e.dz) begin
                chk({tag, "_dz_latency"}, n, 0);
                chk({tag, "_starts"}, start_cnt - s0, 0);
            end else if (got_e.to) begin
                chk({tag, "_to_latency"}, cyc - start_cyc, TO + 1);
                chk({tag, "_starts"}, start_cnt - s0, 1);
            end else begin
                chk({tag, "_latency"}, cyc - edone_cyc, got_e.lat);
                chk({tag, "_starts"}, start_cnt - s0, 1);
            end
            cur_hi = got_e.hi;
            cur_lo = got_e.lo;
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            if (poke) begin
                repeat (3) @(negedge clk);
                chk({tag, "_no_queue"}, start_cnt - s0, 1);
                chk({tag, "_idle_after"}, busy, 0);
            end
        end
    endtask

    initial begin
        int d0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        spur_done = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_sel", eng_sel, 0);
        chk("rst_eng_a", eng_a, 0);
        chk("rst_eng_b", eng_b, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32, 0, 0);
        chk("divu_lo_const", lo, 14);
        chk("divu_hi_const", hi, 2);
        chk("divu_eng_sel", st_sel, 1);
        chk("divu_eng_a", st_a, 100);
        chk("divu_eng_b", st_b, 7);

        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32, 0, 0);
        chk("dz_hi_kept", hi, 2);
        chk("dz_lo_kept", lo, 14);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0, 0);
        chk("multu_max_sel", st_sel, 0);

        run_op("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32, 0, 0);
`ifdef MULDIV_SIGNED_EN
        chk("mult_m3_5_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_m3_5_eng_a", st_a, 3);
`else
        chk("mult_m3_5_hi_const", hi, 32'h0000_0004);
        chk("mult_m3_5_eng_a", st_a, 32'hFFFF_FFFD);
`endif
        chk("mult_m3_5_lo_const", lo, 32'hFFFF_FFF1);

        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32, 0, 0);
`ifdef MULDIV_SIGNED_EN
        chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
        chk("div_m7_2_eng_a", st_a, 7);
        chk("div_m7_2_eng_b", st_b, 2);
`endif

        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, 0, 0);
`ifdef MULDIV_SIGNED_EN
        chk("div_min_m1_lo_const", lo, 32'h8000_0000);
        chk("div_min_m1_hi_const", hi, 0);
`endif

        run_op("mult_neg_pos", OP_MULT, 32'h8000_0000, 32'd3, 7, 0, 0);
        run_op("multu_fast", OP_MULTU, 32'd123456, 32'd789, 1, 0, 0);
        run_op("divu_edge", OP_DIVU, 32'd1000, 32'd3, TO, 0, 0);
        run_op("divu_poke", OP_DIVU, 32'd77, 32'd5, 20, 0, 1);

        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_done", done, 0);
        chk("spur_hi", hi, cur_hi);
        chk("spur_lo", lo, cur_lo);
        chk("spur_busy", busy, 0);

        run_op("timeout", OP_MULTU, 32'd9, 32'd9, 32, 1, 0);
        eng_mute = 1'b0;

        eng_delay = 32;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = OP_MULTU;
        req_a = 32'd11;
        req_b = 32'd13;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 1);
        reset_n = 1'b1;
        cur_hi = 0;
        cur_lo = 0;
        d0 = done_cnt;
        repeat (45) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

        run_op("after_rst", OP_MULTU, 32'd6, 32'd7, 32, 0, 0);
        chk("after_rst_lo_const", lo, 42);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
